ctlr_serial_port: RTL and testbench
===================================

// Module: ctlr_serial_port
// PURPOSE
//  Parametrised NES-style serial gamepad port for the CPU bus; replaces the fixed 2-pad controller interface.
//  Decodes CPU accesses to BASE_ADDR..BASE_ADDR+NUM_PORTS-1 and drives the shared latch and per-port active-low clock pulses.
//  Pulses are PULSE_LEN clock_en cycles wide. Serial data is returned on button_data_rd.
//  Also captures each port's 8-bit button frame for debug and peripherals.
// PARAMETERS
//  NUM_PORTS   2         number of pad ports, 1..4; port i decoded at BASE_ADDR+i
//  PULSE_LEN   3         width of ctlr_pulse low phase, in clock_en cycles, 1..15
//  BASE_ADDR   16'h4016  CPU address of port 0 and of the latch register
//  OPEN_BUS    7'h00     constant driven on button_data_rd[7:1]
//  INVERT_DATA 1         1: pad data pins are active-low (bit = ~pin)
// PORTS
//  clock           in   1            system clock
//  reset_n         in   1            asynchronous, active-low reset
//  clock_en        in   1            CPU cycle enable; all state advances only when high
//  addr            in   16           CPU address
//  r_en            in   1            1 = read, 0 = write
//  w_data          in   8            CPU write data
//  ctlr_data       in   NUM_PORTS    serial data pin per port
//  ctlr_pulse      out  NUM_PORTS    per-port shift clock, idle high, active low
//  ctlr_latch      out  1            shared latch/strobe to all pads
//  button_data_rd  out  8            registered read data {OPEN_BUS, bit}
//  button_state    out  8*NUM_PORTS  last captured frame per port; port i at [8i+7:8i]; bit k = k-th read
//  button_state_vld out NUM_PORTS    1-cycle strobe: frame of port i complete
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset values: ctlr_pulse all 1; ctlr_latch 0; button_data_rd 0; button_state 0; button_state_vld 0.
//   Internal bit_cnt[i] (4b) and pulse_cnt[i] also reset to 0.
//  Cycle gating: every register below updates only on clock edges with clock_en=1.
//  Latch: a write (r_en=0) to BASE_ADDR loads ctlr_latch <= w_data[0] on the next edge.
//   A write to any other port address is ignored.
//   When ctlr_latch transitions 1->0, all bit_cnt are cleared to 0.
//   While ctlr_latch=1, bit_cnt is held at 0.
//  Read accept: r_en=1 and addr==BASE_ADDR+i, i<NUM_PORTS.
//   The CPU presents each access for exactly one clock_en cycle.
//  Read data: button_data_rd <= {OPEN_BUS, b}, one-edge latency; holds its value until the next accepted read.
//   b = ctlr_data[i]^INVERT_DATA when bit_cnt[i]<8 or latch=1; b = 1 when bit_cnt[i]==8 (post-frame).
//  Pulse generation (latch=0, bit_cnt[i]<8):
//   On an accepted read, pulse_cnt[i] <= PULSE_LEN and bit_cnt[i] increments.
//   ctlr_pulse[i] = 0 while pulse_cnt[i]!=0, else 1 (registered).
//   pulse_cnt decrements once per clock_en cycle.
//   A read during an active pulse reloads pulse_cnt (pulse is extended, not duplicated).
//  No pulse is generated when latch=1 or bit_cnt[i]==8; bit_cnt saturates at 8.
//  Frame capture: each accepted read with bit_cnt<8 and latch=0 writes b into shadow[i][bit_cnt].
//   On the read that moves bit_cnt 7->8, button_state[i] <= completed shadow and button_state_vld[i]=1 for one clock_en cycle.
//  Simultaneous events: a latch write and a read cannot coincide (single bus).
//   The falling latch edge and bit_cnt clear take effect on the same edge.
//   The next read of the same port then returns bit 0.
//  Reset mid-pulse: ctlr_pulse returns high immediately (async); the partial frame is discarded.
//  Non-matching addresses: no state change other than pulse_cnt countdown.
// TESTING
//  Reset asserted mid-pulse -> ctlr_pulse=all 1, button_data_rd=0, no vld, even before the clock.
//  Write 0x01 then 0x00 to 0x4016, pin0 pattern A=0 (pressed) -> first read of 0x4016 gives 0x01.
//   ctlr_pulse[0] low exactly 3 clock_en cycles, starting the edge after the read.
//  8 reads of 0x4016 with pins giving bits 1,0,1,1,0,0,0,1 -> button_state[7:0]=0x8D.
//   button_state_vld[0] pulses once; 9th read returns 0x01 with no pulse.
//  Latch held at 1, 3 reads of 0x4017 -> each returns current port-1 bit; ctlr_pulse[1] stays 1; bit_cnt stays 0.
//  Read 0x4016 on back-to-back clock_en cycles -> a single merged low pulse of 4 cycles; bit_cnt advances by 2.
//  NUM_PORTS=4, OPEN_BUS=7'h20: read 0x4019 -> 0x40|bit; only ctlr_pulse[3] pulses.
//   A write to 0x4017 leaves the latch unchanged.

Source files
------------

// File: rtl/ctlr_serial_port_if.sv
// CPU-side bus of the serial gamepad port: cycle enable, address, direction and data.
interface ctlr_serial_port_if;
  logic        clock_en;
  logic [15:0] addr;
  logic        r_en;
  logic [7:0]  w_data;
  logic [7:0]  button_data_rd;

  modport master (output clock_en, addr, r_en, w_data, input button_data_rd);
  modport slave  (input clock_en, addr, r_en, w_data, output button_data_rd);
endinterface

// File: rtl/ctlr_serial_port.sv
// NES-style serial gamepad port: shared latch, per-port shift-clock pulses,
// registered serial read data and 8-bit frame capture per port.
module ctlr_serial_port #(
  parameter int          NUM_PORTS   = 2,
  parameter int          PULSE_LEN   = 3,
  parameter logic [15:0] BASE_ADDR   = 16'h4016,
  parameter logic [6:0]  OPEN_BUS    = 7'h00,
  parameter bit          INVERT_DATA = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  ctlr_serial_port_if.slave      bus,
  input  logic [NUM_PORTS-1:0]   ctlr_data,
  output logic [NUM_PORTS-1:0]   ctlr_pulse,
  output logic                   ctlr_latch,
  output logic [8*NUM_PORTS-1:0] button_state,
  output logic [NUM_PORTS-1:0]   button_state_vld
);

  logic [3:0] bit_cnt   [NUM_PORTS];
  logic [3:0] pulse_cnt [NUM_PORTS];
  logic [7:0] shadow    [NUM_PORTS];

  logic [NUM_PORTS-1:0] rd_hit;
  logic [NUM_PORTS-1:0] bit_val;
  logic [NUM_PORTS-1:0] advance;
  logic                 rd_any;
  logic                 rd_bit;
  logic                 latch_wr;
  logic                 unused_wdata;

  assign unused_wdata = ^bus.w_data[7:1];

  always_comb begin
    rd_hit  = '0;
    bit_val = '0;
    advance = '0;
    rd_bit  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_hit[i]  = bus.r_en && (bus.addr == BASE_ADDR + 16'(i));
      // Once a frame is exhausted the pad keeps returning 1 until re-latched.
      bit_val[i] = (bit_cnt[i] == 4'd8 && !ctlr_latch) ? 1'b1 : (ctlr_data[i] ^ INVERT_DATA);
      advance[i] = rd_hit[i] && !ctlr_latch && (bit_cnt[i] != 4'd8);
      if (rd_hit[i]) rd_bit = bit_val[i];
    end
    rd_any   = |rd_hit;
    latch_wr = !bus.r_en && (bus.addr == BASE_ADDR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctlr_latch         <= 1'b0;
      bus.button_data_rd <= 8'h00;
      ctlr_pulse         <= '1;
      button_state       <= '0;
      button_state_vld   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        bit_cnt[i]   <= 4'd0;
        pulse_cnt[i] <= 4'd0;
        shadow[i]    <= 8'h00;
      end
    end else if (bus.clock_en) begin
      if (latch_wr) ctlr_latch <= bus.w_data[0];
      if (rd_any) bus.button_data_rd <= {OPEN_BUS, rd_bit};
      button_state_vld <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        ctlr_pulse[i] <= (pulse_cnt[i] == 4'd0);
        // A read during an active pulse reloads the timer, stretching one pulse.
        if (advance[i]) pulse_cnt[i] <= 4'(PULSE_LEN);
        else if (pulse_cnt[i] != 4'd0) pulse_cnt[i] <= pulse_cnt[i] - 4'd1;

        if (ctlr_latch) begin
          bit_cnt[i] <= 4'd0;
        end else if (advance[i]) begin
          bit_cnt[i] <= bit_cnt[i] + 4'd1;
          shadow[i][bit_cnt[i][2:0]] <= bit_val[i];
          if (bit_cnt[i] == 4'd7) begin
            button_state[8*i +: 8] <= {bit_val[i], shadow[i][6:0]};
            button_state_vld[i]    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ctlr_serial_port.sv
// Bench for ctlr_serial_port: directed scenarios followed by random bus traffic,
// checked against a frame/pulse-window reference model.
module tb_ctlr_serial_port;
  localparam int          NP   = 4;
  localparam int          PL   = 3;
  localparam logic [15:0] BASE = 16'h4016;
  localparam logic [6:0]  OB   = 7'h20;
  localparam bit          INV  = 1'b1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NP-1:0]   ctlr_data;
  logic [NP-1:0]   ctlr_pulse;
  logic            ctlr_latch;
  logic [8*NP-1:0] button_state;
  logic [NP-1:0]   button_state_vld;

  ctlr_serial_port_if bus ();

  ctlr_serial_port #(
    .NUM_PORTS(NP), .PULSE_LEN(PL), .BASE_ADDR(BASE), .OPEN_BUS(OB), .INVERT_DATA(INV)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .ctlr_data(ctlr_data),
    .ctlr_pulse(ctlr_pulse), .ctlr_latch(ctlr_latch),
    .button_state(button_state), .button_state_vld(button_state_vld)
  );

  always #5 clock = ~clock;

  // reference model
  int         m_bitc  [NP];
  int         m_last  [NP];
  int         m_prev  [NP];
  logic [7:0] m_frame [NP];
  logic [7:0] m_state [NP];
  logic [NP-1:0] m_vld;
  logic [7:0] m_rd;
  logic       m_latch;
  int         m_edge;

  int total = 0;
  int bad = 0;
  int low_cnt [NP];
  int vld0_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_bitc[i] = 0; m_last[i] = -1000; m_prev[i] = -1000;
      m_frame[i] = 8'h00; m_state[i] = 8'h00;
    end
    m_vld = '0; m_rd = 8'h00; m_latch = 1'b0; m_edge = 0;
  endtask

  task automatic model_edge(input logic [15:0] addr, input logic r_en,
                            input logic [7:0] wdata, input logic [NP-1:0] pins);
    logic old_latch;
    logic b;
    int p;
    old_latch = m_latch;
    m_edge++;
    m_vld = '0;
    if (!r_en && addr == BASE) m_latch = wdata[0];
    if (old_latch) for (int i = 0; i < NP; i++) m_bitc[i] = 0;
    if (r_en && addr >= BASE && addr < BASE + 16'(NP)) begin
      p = int'(addr - BASE);
      b = (m_bitc[p] == 8 && !old_latch) ? 1'b1 : (pins[p] ^ INV);
      m_rd = {OB, b};
      if (!old_latch && m_bitc[p] < 8) begin
        m_frame[p][m_bitc[p]] = b;
        m_prev[p] = m_last[p];
        m_last[p] = m_edge;
        if (m_bitc[p] == 7) begin
          m_state[p] = m_frame[p];
          m_vld[p] = 1'b1;
        end
        m_bitc[p]++;
      end
    end
  endtask

  // A pulse is low on the PL clock_en edges following each pulse-producing read.
  function automatic logic [NP-1:0] exp_pulse();
    logic [NP-1:0] e;
    e = '1;
    for (int i = 0; i < NP; i++)
      if ((m_edge > m_last[i] && m_edge <= m_last[i] + PL) ||
          (m_edge > m_prev[i] && m_edge <= m_prev[i] + PL)) e[i] = 1'b0;
    return e;
  endfunction

  task automatic check_all(input string tag);
    logic [8*NP-1:0] st;
    for (int i = 0; i < NP; i++) st[8*i +: 8] = m_state[i];
    check({tag, ".rd"},    32'(bus.button_data_rd), 32'(m_rd));
    check({tag, ".latch"}, 32'(ctlr_latch),         32'(m_latch));
    check({tag, ".pulse"}, 32'(ctlr_pulse),         32'(exp_pulse()));
    check({tag, ".state"}, 32'(button_state),       32'(st));
    check({tag, ".vld"},   32'(button_state_vld),   32'(m_vld));
  endtask

  task automatic step(input string tag, input logic [15:0] addr, input logic r_en,
                      input logic [7:0] wdata, input logic ce, input logic [NP-1:0] pins);
    bus.addr = addr; bus.r_en = r_en; bus.w_data = wdata; bus.clock_en = ce;
    ctlr_data = pins;
    @(posedge clock);
    #1;
    if (ce) model_edge(addr, r_en, wdata, pins);
    check_all(tag);
    for (int i = 0; i < NP; i++) if (!ctlr_pulse[i]) low_cnt[i]++;
    if (button_state_vld[0]) vld0_cnt++;
    bus.addr = 16'h0000; bus.r_en = 1'b0; bus.w_data = 8'h00; bus.clock_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 16'h0000, 1'b0, 8'h00, 1'b1, '1);
  endtask

  task automatic clear_lows();
    for (int i = 0; i < NP; i++) low_cnt[i] = 0;
  endtask

  initial begin
    logic [7:0]    pattern;
    logic [NP-1:0] pins;
    logic [15:0]   raddr;
    int            r;

    model_reset();
    clear_lows();
    bus.clock_en = 1'b1; bus.addr = 16'h0000; bus.r_en = 1'b0; bus.w_data = 8'h00;
    ctlr_data = '1;
    #12;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // reset asserted in the middle of a pulse
    step("mp_l1", BASE, 1'b0, 8'h01, 1'b1, '1);
    step("mp_l0", BASE, 1'b0, 8'h00, 1'b1, '1);
    step("mp_rd", BASE, 1'b1, 8'h00, 1'b1, 4'b1110);
    step("mp_idle", 16'h0000, 1'b0, 8'h00, 1'b1, '1);
    check("mp_low_before", 32'(ctlr_pulse[0]), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mp_pulse", 32'(ctlr_pulse), 32'hF);
    check("mp_rd",    32'(bus.button_data_rd), 32'h0);
    check("mp_vld",   32'(button_state_vld), 32'h0);
    check("mp_state", 32'(button_state), 32'h0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // first read after latch, then a full frame of 1,0,1,1,0,0,0,1
    step("l1", BASE, 1'b0, 8'h01, 1'b1, '1);
    step("l0", BASE, 1'b0, 8'h00, 1'b1, '1);
    clear_lows();
    vld0_cnt = 0;
    step("rd0", BASE, 1'b1, 8'h00, 1'b1, 4'b1110);
    check("first_read", 32'(bus.button_data_rd), 32'h41);
    check("pulse_start", 32'(ctlr_pulse[0]), 32'd1);
    idle(5);
    check("pulse_len", 32'(low_cnt[0]), 32'd3);
    pattern = 8'b1000_1101;
    for (int k = 1; k < 8; k++) begin
      pins = '1;
      pins[0] = ~pattern[k];
      step("frame_rd", BASE, 1'b1, 8'h00, 1'b1, pins);
      idle(4);
    end
    check("frame_val", 32'(button_state[7:0]), 32'h8D);
    check("vld_once",  32'(vld0_cnt), 32'd1);
    clear_lows();
    step("rd9", BASE, 1'b1, 8'h00, 1'b1, '1);
    check("post_frame", 32'(bus.button_data_rd), 32'h41);
    idle(5);
    check("post_frame_nopulse", 32'(low_cnt[0]), 32'd0);

    // latch held high: reads return live pin, no pulses
    step("lh1", BASE, 1'b0, 8'h01, 1'b1, '1);
    clear_lows();
    for (int k = 0; k < 3; k++) begin
      pins = 4'($urandom);
      step("lh_rd", BASE + 16'd1, 1'b1, 8'h00, 1'b1, pins);
      check("lh_live", 32'(bus.button_data_rd), 32'({OB, pins[1] ^ INV}));
      idle(1);
    end
    idle(3);
    check("lh_nopulse", 32'(low_cnt[1]), 32'd0);
    step("lh0", BASE, 1'b0, 8'h00, 1'b1, '1);

    // back-to-back reads merge into one stretched pulse
    clear_lows();
    step("bb1", BASE, 1'b1, 8'h00, 1'b1, 4'b0000);
    step("bb2", BASE, 1'b1, 8'h00, 1'b1, 4'b1111);
    idle(6);
    check("bb_len", 32'(low_cnt[0]), 32'd4);
    for (int k = 0; k < 6; k++) begin
      step("bb_fill", BASE, 1'b1, 8'h00, 1'b1, 4'($urandom));
      idle(4);
    end

    // highest port; other ports stay idle; writes to non-latch port ignored
    clear_lows();
    step("p3_rd", BASE + 16'd3, 1'b1, 8'h00, 1'b1, 4'b1000);
    check("p3_data", 32'(bus.button_data_rd), 32'h40);
    idle(5);
    check("p3_len",    32'(low_cnt[3]), 32'd3);
    check("p3_others", 32'(low_cnt[0] + low_cnt[1] + low_cnt[2]), 32'd0);
    step("wr4017", BASE + 16'd1, 1'b0, 8'h01, 1'b1, '1);
    check("wr4017_latch", 32'(ctlr_latch), 32'd0);
    step("oob_rd", BASE + 16'd4, 1'b1, 8'h00, 1'b1, '0);
    step("gated_rd", BASE, 1'b1, 8'h00, 1'b0, '0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      raddr = (r < 6) ? BASE + 16'($urandom_range(0, 4)) : 16'($urandom);
      step("rnd", raddr, ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 99) < 85), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
